// File: rtl/hsv_vision_pkg.sv
// Shared types and constants for the HSV colour-tracking pipeline.
package hsv_vision_pkg;

  localparam int IMAGE_W = 640;
  localparam int IMAGE_H = 480;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int CNT_W   = 19;

  localparam logic [8:0] HUE_MAX = 9'd359;

  typedef struct packed {
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic [CNT_W-1:0] count;
  } bbox_t;

  // Empty box: mins at all-ones so the first matched pixel always wins.
  localparam bbox_t BBOX_EMPTY = '{
    x_min: {X_W{1'b1}},
    x_max: {X_W{1'b0}},
    y_min: {Y_W{1'b1}},
    y_max: {Y_W{1'b0}},
    count: {CNT_W{1'b0}}
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/hsv_threshold.sv
// Combinational HSV colour-window test; hue window wraps through 0 when h_lo > h_hi.
module hsv_threshold (
  input  logic [8:0] h,
  input  logic [7:0] s,
  input  logic [7:0] v,
  input  logic [8:0] h_lo,
  input  logic [8:0] h_hi,
  input  logic [7:0] s_min,
  input  logic [7:0] v_min,
  output logic       match
);
  import hsv_vision_pkg::*;

  logic hue_ok_s;

  // Hue outside the legal circle never matches, even inside a wrapped window.
  always_comb begin
    hue_ok_s = 1'b0;
    if (h > HUE_MAX) begin
      hue_ok_s = 1'b0;
    end else if (h_lo <= h_hi) begin
      hue_ok_s = (h >= h_lo) && (h <= h_hi);
    end else begin
      hue_ok_s = (h >= h_lo) || (h <= h_hi);
    end
    match = hue_ok_s && (s >= s_min) && (v >= v_min);
  end

endmodule

// File: rtl/hsv_colour_bbox.sv
// Thresholds an HSV pixel stream into a mask and publishes one bounding box
// plus matched-pixel count per frame.
module hsv_colour_bbox #(
  parameter int IMAGE_W    = hsv_vision_pkg::IMAGE_W,
  parameter int IMAGE_H    = hsv_vision_pkg::IMAGE_H,
  parameter int X_W        = hsv_vision_pkg::X_W,
  parameter int Y_W        = hsv_vision_pkg::Y_W,
  parameter int CNT_W      = hsv_vision_pkg::CNT_W,
  parameter int MIN_PIXELS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [8:0]       hsv_h,
  input  logic [7:0]       hsv_s,
  input  logic [7:0]       hsv_v,
  input  logic [8:0]       h_lo,
  input  logic [8:0]       h_hi,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask_valid,
  output logic             mask,
  output logic             res_valid,
  output logic             found,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [CNT_W-1:0] pix_count
);
  import hsv_vision_pkg::*;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMAGE_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMAGE_H - 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

  state_t         state_r, state_nx_s;
  logic [X_W-1:0] x_cnt_r, pix_x_s, x_nx_s, px_x_r;
  logic [Y_W-1:0] y_cnt_r, pix_y_s, y_nx_s, px_y_r;
  logic [8:0]     sh_h_lo_r, sh_h_hi_r, win_h_lo_s, win_h_hi_s;
  logic [7:0]     sh_s_min_r, sh_v_min_r, win_s_min_s, win_v_min_s;
  logic           sop_beat_s, frame_open_s, match_s, px_sop_r;
  bbox_t          acc_r, acc_base_s, acc_nx_s;

  assign sop_beat_s   = in_valid & in_sop;
  assign frame_open_s = (state_r == ST_ACTIVE) | in_sop;

  // The sop pixel is judged against the live ports; the rest of the frame against the shadow copy.
  assign win_h_lo_s  = sop_beat_s ? h_lo  : sh_h_lo_r;
  assign win_h_hi_s  = sop_beat_s ? h_hi  : sh_h_hi_r;
  assign win_s_min_s = sop_beat_s ? s_min : sh_s_min_r;
  assign win_v_min_s = sop_beat_s ? v_min : sh_v_min_r;

  hsv_threshold u_threshold (
    .h     (hsv_h),
    .s     (hsv_s),
    .v     (hsv_v),
    .h_lo  (win_h_lo_s),
    .h_hi  (win_h_hi_s),
    .s_min (win_s_min_s),
    .v_min (win_v_min_s),
    .match (match_s)
  );

  // Current pixel coordinate and the coordinate the next beat will take.
  always_comb begin
    pix_x_s = in_sop ? {X_W{1'b0}} : x_cnt_r;
    pix_y_s = in_sop ? {Y_W{1'b0}} : y_cnt_r;
    x_nx_s  = pix_x_s + X_W'(1);
    y_nx_s  = pix_y_s;
    if (pix_x_s == X_LAST) begin
      x_nx_s = {X_W{1'b0}};
      if (pix_y_s == Y_LAST) begin
        y_nx_s = pix_y_s;
      end else begin
        y_nx_s = pix_y_s + Y_W'(1);
      end
    end else begin
      y_nx_s = pix_y_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt_r    <= {X_W{1'b0}};
      y_cnt_r    <= {Y_W{1'b0}};
      sh_h_lo_r  <= 9'd0;
      sh_h_hi_r  <= 9'd0;
      sh_s_min_r <= 8'd0;
      sh_v_min_r <= 8'd0;
    end else begin
      if (in_valid) begin
        x_cnt_r <= x_nx_s;
        y_cnt_r <= y_nx_s;
      end
      if (sop_beat_s) begin
        sh_h_lo_r  <= h_lo;
        sh_h_hi_r  <= h_hi;
        sh_s_min_r <= s_min;
        sh_v_min_r <= v_min;
      end
    end
  end

  // Stage 1: registered mask stream with the pixel's coordinate and frame-start flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_valid <= 1'b0;
      mask       <= 1'b0;
      px_sop_r   <= 1'b0;
      px_x_r     <= {X_W{1'b0}};
      px_y_r     <= {Y_W{1'b0}};
    end else begin
      mask_valid <= in_valid;
      mask       <= in_valid & match_s & frame_open_s;
      px_sop_r   <= sop_beat_s;
      if (in_valid) begin
        px_x_r <= pix_x_s;
        px_y_r <= pix_y_s;
      end
    end
  end

  // Stage 2: a frame start reseeds the accumulator before folding in its own pixel.
  always_comb begin
    acc_base_s = px_sop_r ? BBOX_EMPTY : acc_r;
    acc_nx_s   = acc_base_s;
    if (mask) begin
      acc_nx_s.x_min = (px_x_r < acc_base_s.x_min) ? px_x_r : acc_base_s.x_min;
      acc_nx_s.x_max = (px_x_r > acc_base_s.x_max) ? px_x_r : acc_base_s.x_max;
      acc_nx_s.y_min = (px_y_r < acc_base_s.y_min) ? px_y_r : acc_base_s.y_min;
      acc_nx_s.y_max = (px_y_r > acc_base_s.y_max) ? px_y_r : acc_base_s.y_max;
      if (acc_base_s.count == {CNT_W{1'b1}}) begin
        acc_nx_s.count = acc_base_s.count;
      end else begin
        acc_nx_s.count = acc_base_s.count + CNT_W'(1);
      end
    end else begin
      acc_nx_s = acc_base_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= BBOX_EMPTY;
    end else begin
      acc_r <= acc_nx_s;
    end
  end

  // A sop in IDLE, ACTIVE or PUBLISH (re)starts a frame; with eop on the same beat it is a one-pixel frame.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sop_beat_s) begin
          state_nx_s = in_eop ? ST_FLUSH : ST_ACTIVE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (in_valid & in_eop) begin
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        state_nx_s = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        if (sop_beat_s) begin
          state_nx_s = in_eop ? ST_FLUSH : ST_ACTIVE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Publish: results latch while leaving PUBLISH and hold until the next frame's publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      found     <= 1'b0;
      x_min     <= {X_W{1'b0}};
      x_max     <= {X_W{1'b0}};
      y_min     <= {Y_W{1'b0}};
      y_max     <= {Y_W{1'b0}};
      pix_count <= {CNT_W{1'b0}};
    end else if (state_r == ST_PUBLISH) begin
      res_valid <= 1'b1;
      pix_count <= acc_r.count;
      if (acc_r.count >= CNT_MIN) begin
        found <= 1'b1;
        x_min <= acc_r.x_min;
        x_max <= acc_r.x_max;
        y_min <= acc_r.y_min;
        y_max <= acc_r.y_max;
      end else begin
        found <= 1'b0;
        x_min <= {X_W{1'b0}};
        x_max <= {X_W{1'b0}};
        y_min <= {Y_W{1'b0}};
        y_max <= {Y_W{1'b0}};
      end
    end else begin
      res_valid <= 1'b0;
    end
  end

endmodule
